// File: rtl/piso_serializer_if.sv
// piso_serializer_if: load handshake and serial stream bundle for piso_serializer
//   din        parallel word from the producer, sampled on handshake
//   load_valid producer has a word on din
//   load_ready serializer accepts a word this cycle
//   sout       serial data bit
//   sout_valid sout carries a frame bit this cycle
//   busy       frame in progress
//   done       one-cycle pulse during the final bit of a frame
interface piso_serializer_if #(parameter int WIDTH = 4);
  logic [WIDTH-1:0] din;
  logic             load_valid;
  logic             load_ready;
  logic             sout;
  logic             sout_valid;
  logic             busy;
  logic             done;
  modport master (output din, load_valid, input load_ready, sout, sout_valid, busy, done);
  modport slave  (input din, load_valid, output load_ready, sout, sout_valid, busy, done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: accepts a WIDTH-bit word over valid/ready and emits it one bit per clk
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    piso_serializer_if.slave: din/load_valid in, load_ready/sout/sout_valid/busy/done out
//   Optional macro PARITY_EN appends one even-parity bit to every frame.
module piso_serializer #(
  parameter int WIDTH     = 4,
  parameter int MSB_FIRST = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  piso_serializer_if.slave      bus
);
  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
`ifdef PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, SHIFT} state_t;
`endif
  state_t           r_state, w_st_nxt;
  logic [WIDTH-1:0] r_shift, w_shift_nxt, w_shifted;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic             r_sout, r_sout_valid, r_busy, r_done;
  logic             w_sout_nxt, w_valid_nxt, w_done_nxt;
  logic             w_last, w_accept, w_ready;
`ifdef PARITY_EN
  logic             r_par;
`endif
  assign w_last    = (r_state == SHIFT) && (r_cnt == LAST);
`ifdef PARITY_EN
  assign w_ready   = (r_state == IDLE) || (r_state == PAR);
`else
  // the last data bit frees the slot so the next frame follows with no gap
  assign w_ready   = (r_state == IDLE) || w_last;
`endif
  assign w_accept  = bus.load_valid && w_ready;
  assign w_shifted = (MSB_FIRST != 0) ? {r_shift[WIDTH-2:0], 1'b0} : {1'b0, r_shift[WIDTH-1:1]};
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_shift <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_st_nxt;
      r_shift <= w_shift_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end
`ifdef PARITY_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_par <= 1'b0;
    else if (w_accept) r_par <= ^bus.din;
  end
`endif
  always_comb begin
    w_st_nxt = IDLE;
`ifdef PARITY_EN
    if (w_accept) w_st_nxt = SHIFT;
    else if (r_state == SHIFT) w_st_nxt = w_last ? PAR : SHIFT;
`else
    if (w_accept) w_st_nxt = SHIFT;
    else if (r_state == SHIFT && !w_last) w_st_nxt = SHIFT;
`endif
  end
  // a fresh word loads the register; otherwise it shifts while in SHIFT and fills with 0
  assign w_shift_nxt = w_accept ? bus.din : (r_state == SHIFT) ? w_shifted : r_shift;
  assign w_cnt_nxt   = (!w_accept && r_state == SHIFT && !w_last) ? r_cnt + 1'b1 : '0;
  // next-cycle values for the registered outputs
  always_comb begin
    w_sout_nxt  = 1'b0;
    w_valid_nxt = (w_st_nxt != IDLE);
    w_done_nxt  = 1'b0;
    if (w_st_nxt == SHIFT) w_sout_nxt = (MSB_FIRST != 0) ? w_shift_nxt[WIDTH-1] : w_shift_nxt[0];
`ifdef PARITY_EN
    if (w_st_nxt == PAR) w_sout_nxt = r_par;
    w_done_nxt = (w_st_nxt == PAR);
`else
    w_done_nxt = (w_st_nxt == SHIFT) && (w_cnt_nxt == LAST);
`endif
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sout       <= 1'b0;
      r_sout_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_sout       <= w_sout_nxt;
      r_sout_valid <= w_valid_nxt;
      r_busy       <= w_valid_nxt;
      r_done       <= w_done_nxt;
    end
  end
  assign bus.load_ready = w_ready;
  assign bus.sout       = r_sout;
  assign bus.sout_valid = r_sout_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;
endmodule
